shift_exec_stage: RTL and testbench

Two-stage pipelined execute wrapper around the combinational 32-bit barrel shifter.
- Stage 1 decodes MIPS R-type shift instructions (SLL/SRL/SRA/SLLV/SRLV/SRAV), selects operands and registers the shifter inputs T/shamt/type.
- Stage 2 registers the shifter result plus N/Z/C flags and the destination register for writeback.
- Valid/ready handshakes on both sides; sits between the ID/EX operand latch and writeback.

---
 rtl/shift_exec_stage.sv | 160 ++++++++++++++++
 tb/tb_shift_exec_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Two-stage execute wrapper around an external combinational barrel shifter.
// Stage 1 decodes R-type shifts and drives the shifter; stage 2 captures result, flags and rd.
module shift_exec_stage #(
  parameter logic [4:0] TYPE_SLL = 5'h0C,
  parameter logic [4:0] TYPE_SRL = 5'h0D,
  parameter logic [4:0] TYPE_SRA = 5'h0E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  output logic [31:0] sh_T,
  output logic [4:0]  sh_shamt,
  output logic [4:0]  sh_type,
  input  logic [31:0] sh_Y,
  input  logic        sh_C,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_Y,
  output logic        out_C,
  output logic        out_N,
  output logic        out_Z,
  output logic [4:0]  out_rd,
  output logic        illegal
);

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] sh_t_q, sh_t_d;
  logic [4:0]  sh_shamt_q, sh_shamt_d;
  logic [4:0]  sh_type_q, sh_type_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [31:0] out_y_q, out_y_d;
  logic        out_c_q, out_c_d;
  logic        out_n_q, out_n_d;
  logic        out_z_q, out_z_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        illegal_q, illegal_d;

  logic        dec_legal;
  logic [4:0]  dec_type;
  logic [4:0]  dec_shamt;
  logic        s1_adv, s2_adv, accept;

  // Only rs[4:0] feeds variable shifts; the rs/rt register fields are not needed.
  logic unused_bits;
  assign unused_bits = ^{in_rs[31:5], in_ir[25:16]};

  always_comb begin
    dec_legal = 1'b0;
    dec_type  = TYPE_SLL;
    dec_shamt = in_ir[10:6];
    if (in_ir[31:26] == 6'd0) begin
      case (in_ir[5:0])
        6'h00: begin dec_legal = 1'b1; dec_type = TYPE_SLL; end
        6'h02: begin dec_legal = 1'b1; dec_type = TYPE_SRL; end
        6'h03: begin dec_legal = 1'b1; dec_type = TYPE_SRA; end
        6'h04: begin dec_legal = 1'b1; dec_type = TYPE_SLL; dec_shamt = in_rs[4:0]; end
        6'h06: begin dec_legal = 1'b1; dec_type = TYPE_SRL; dec_shamt = in_rs[4:0]; end
        6'h07: begin dec_legal = 1'b1; dec_type = TYPE_SRA; dec_shamt = in_rs[4:0]; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    s1_adv   = s1_valid_q & s2_adv;
    in_ready = (!s1_valid_q | s2_adv) & !flush;
    accept   = in_valid & in_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    sh_t_d     = sh_t_q;
    sh_shamt_d = sh_shamt_q;
    sh_type_d  = sh_type_q;
    s1_rd_d    = s1_rd_q;
    out_y_d    = out_y_q;
    out_c_d    = out_c_q;
    out_n_d    = out_n_q;
    out_z_d    = out_z_q;
    out_rd_d   = out_rd_q;
    illegal_d  = accept & !dec_legal;

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      out_y_d    = sh_Y;
      out_c_d    = sh_C;
      out_n_d    = sh_Y[31];
      out_z_d    = (sh_Y == 32'd0);
      out_rd_d   = s1_rd_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (accept && dec_legal) begin
      s1_valid_d = 1'b1;
      sh_t_d     = in_rt;
      sh_shamt_d = dec_shamt;
      sh_type_d  = dec_type;
      s1_rd_d    = in_ir[15:11];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Flush discards everything in flight; a same-edge output handshake is already consumed.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sh_t_q     <= 32'd0;
      sh_shamt_q <= 5'd0;
      sh_type_q  <= TYPE_SLL;
      s1_rd_q    <= 5'd0;
      out_y_q    <= 32'd0;
      out_c_q    <= 1'b0;
      out_n_q    <= 1'b0;
      out_z_q    <= 1'b0;
      out_rd_q   <= 5'd0;
      illegal_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sh_t_q     <= sh_t_d;
      sh_shamt_q <= sh_shamt_d;
      sh_type_q  <= sh_type_d;
      s1_rd_q    <= s1_rd_d;
      out_y_q    <= out_y_d;
      out_c_q    <= out_c_d;
      out_n_q    <= out_n_d;
      out_z_q    <= out_z_d;
      out_rd_q   <= out_rd_d;
      illegal_q  <= illegal_d;
    end
  end

  assign sh_T      = sh_t_q;
  assign sh_shamt  = sh_shamt_q;
  assign sh_type   = sh_type_q;
  assign out_valid = s2_valid_q;
  assign out_Y     = out_y_q;
  assign out_C     = out_c_q;
  assign out_N     = out_n_q;
  assign out_Z     = out_z_q;
  assign out_rd    = out_rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Randomized bench for shift_exec_stage: a behavioural shifter drives sh_Y/sh_C and a
// queue-based model of in-flight instructions predicts handshakes, outputs and illegal pulses.
module tb_shift_exec_stage;

  localparam logic [4:0] TSLL = 5'h0C;
  localparam logic [4:0] TSRL = 5'h0D;
  localparam logic [4:0] TSRA = 5'h0E;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_ready, out_valid;
  logic [31:0] in_ir, in_rs, in_rt, sh_T, sh_Y, out_Y;
  logic [4:0]  sh_shamt, sh_type, out_rd;
  logic        sh_C, out_C, out_N, out_Z, illegal;

  always #5 clk = ~clk;

  shift_exec_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_rs(in_rs), .in_rt(in_rt), .sh_T(sh_T), .sh_shamt(sh_shamt),
    .sh_type(sh_type), .sh_Y(sh_Y), .sh_C(sh_C), .out_valid(out_valid),
    .out_ready(out_ready), .out_Y(out_Y), .out_C(out_C), .out_N(out_N), .out_Z(out_Z),
    .out_rd(out_rd), .illegal(illegal)
  );

  // Combinational shifter: carry is the last bit shifted out, 0 for a zero shift.
  logic [63:0] sh_w;
  always_comb begin
    sh_w = 64'd0;
    sh_Y = 32'd0;
    sh_C = 1'b0;
    case (sh_type)
      TSLL: begin sh_w = {32'd0, sh_T} << sh_shamt; sh_Y = sh_w[31:0]; sh_C = sh_w[32]; end
      TSRL: begin sh_w = {sh_T, 32'd0} >> sh_shamt; sh_Y = sh_w[63:32]; sh_C = sh_w[31]; end
      TSRA: begin
        sh_w = 64'($signed({sh_T, 32'd0}) >>> sh_shamt);
        sh_Y = sh_w[63:32];
        sh_C = sh_w[31];
      end
      default: sh_Y = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0] y;
    logic        c;
    logic [4:0]  rd;
    int          age;
  } ent_t;

  ent_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_ill;
  logic [31:0] last_t;
  logic [4:0]  last_sa, last_ty;
  bit          last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [31:0] ir, input logic [31:0] rs,
                                 input logic [31:0] rt, output bit legal,
                                 output logic [4:0] ty, output logic [4:0] sa,
                                 output logic [31:0] y, output logic c);
    legal = (ir[31:26] == 6'd0);
    ty = TSLL;
    sa = ir[10:6];
    case (ir[5:0])
      6'h00: ty = TSLL;
      6'h02: ty = TSRL;
      6'h03: ty = TSRA;
      6'h04: begin ty = TSLL; sa = rs[4:0]; end
      6'h06: begin ty = TSRL; sa = rs[4:0]; end
      6'h07: begin ty = TSRA; sa = rs[4:0]; end
      default: legal = 0;
    endcase
    if (ty == TSLL) y = rt << sa;
    else if (ty == TSRL) y = rt >> sa;
    else y = 32'($signed(rt) >>> sa);
    if (sa == 5'd0) c = 1'b0;
    else if (ty == TSLL) c = rt[32 - int'(sa)];
    else c = rt[int'(sa) - 1];
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] fn, input logic [4:0] sa,
                                     input logic [4:0] rd);
    return {6'd0, 10'h155, rd, sa, fn};
  endfunction

  // One cycle: check everything mid-cycle, then advance the model across the rising edge.
  task automatic step();
    bit          exp_ov, exp_rdy, legal, pop;
    logic [4:0]  ty, sa;
    logic [31:0] y;
    logic        c;
    ent_t        e;
    #1;
    exp_rdy = !flush && (q.size() < 2 || out_ready);
    exp_ov  = q.size() > 0 && q[0].age >= 2;
    check_eq("illegal", 32'(illegal), 32'(exp_ill));
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    check_eq("sh_T", sh_T, last_t);
    check_eq("sh_shamt", 32'(sh_shamt), 32'(last_sa));
    check_eq("sh_type", 32'(sh_type), 32'(last_ty));
    if (exp_ov && out_valid) begin
      check_eq("out_Y", out_Y, q[0].y);
      check_eq("out_C", 32'(out_C), 32'(q[0].c));
      check_eq("out_N", 32'(out_N), 32'(q[0].y[31]));
      check_eq("out_Z", 32'(out_Z), 32'(q[0].y == 32'd0));
      check_eq("out_rd", 32'(out_rd), 32'(q[0].rd));
    end
    last_acc = in_valid && exp_rdy;
    pop = exp_ov && out_ready;
    ref_op(in_ir, in_rs, in_rt, legal, ty, sa, y, c);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (flush) q.delete();
    foreach (q[i]) q[i].age++;
    if (last_acc && legal) begin
      e.y = y; e.c = c; e.rd = in_ir[15:11]; e.age = 1;
      q.push_back(e);
      last_t = in_rt; last_sa = sa; last_ty = ty;
    end
    exp_ill = last_acc && !legal;
    @(negedge clk);
  endtask

  task automatic put(input logic v, input logic [31:0] ir, input logic [31:0] rs,
                     input logic [31:0] rt);
    in_valid = v; in_ir = ir; in_rs = rs; in_rt = rt;
    step();
  endtask

  task automatic model_reset();
    q.delete();
    exp_ill = 0; last_t = 0; last_sa = 0; last_ty = TSLL;
  endtask

  logic [31:0] ops [4];
  logic [5:0]  legal_fn [6] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

  initial begin
    int idx;
    reset = 0; flush = 0; in_valid = 0; in_ir = 0; in_rs = 0; in_rt = 0; out_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst out_Y", out_Y, 32'd0);
    check_eq("rst flags", 32'({out_C, out_N, out_Z}), 32'd0);
    check_eq("rst out_rd", 32'(out_rd), 32'd0);
    check_eq("rst illegal", 32'(illegal), 32'd0);
    check_eq("rst sh_T", sh_T, 32'd0);
    check_eq("rst sh_shamt", 32'(sh_shamt), 32'd0);
    check_eq("rst sh_type", 32'(sh_type), 32'(TSLL));
    @(negedge clk);
    reset = 1;

    // Directed: sll by 31, srav by rs[4:0], srl to zero, zero-shift, illegal add, sllv.
    put(1, mk(6'h00, 5'd31, 5'd9), 32'h0, 32'h0000_0001);
    put(1, mk(6'h07, 5'd0, 5'd3), 32'h0000_0024, 32'h8000_00F8);
    put(1, mk(6'h02, 5'd1, 5'd4), 32'h0, 32'h0000_0001);
    put(1, mk(6'h02, 5'd0, 5'd5), 32'h0, 32'hDEAD_BEEF);
    put(1, mk(6'h20, 5'd0, 5'd7), 32'h1, 32'h2);
    put(1, mk(6'h04, 5'd9, 5'd8), 32'hFFFF_FFE3, 32'h0000_1234);
    repeat (4) put(0, 32'h0, 32'h0, 32'h0);

    // Backpressure: four ops streamed, output stalled for three cycles.
    for (int k = 0; k < 4; k++) ops[k] = mk(legal_fn[k + 1], 5'(k + 2), 5'(k + 20));
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 3);
      if (idx < 4) put(1, ops[idx], 32'h3, 32'hF00F_1234 + 32'(idx));
      else put(0, 32'h0, 32'h0, 32'h0);
      if (last_acc) idx++;
    end
    check_eq("bp all accepted", 32'(idx), 32'd4);
    check_eq("bp drained", 32'(q.size()), 32'd0);

    // Asynchronous reset with both stages full.
    out_ready = 0;
    put(1, mk(6'h03, 5'd7, 5'd1), 32'h0, 32'h8765_4321);
    put(1, mk(6'h00, 5'd3, 5'd2), 32'h0, 32'h0000_0F0F);
    in_valid = 0;
    #2 reset = 0;
    #1;
    check_eq("async rst out_valid", 32'(out_valid), 32'd0);
    check_eq("async rst sh_type", 32'(sh_type), 32'(TSLL));
    model_reset();
    @(negedge clk);
    reset = 1; out_ready = 1;
    repeat (3) put(0, 32'h0, 32'h0, 32'h0);

    // Flush with both stages full and a valid instruction offered.
    out_ready = 0;
    put(1, mk(6'h06, 5'd0, 5'd11), 32'h5, 32'h1111_0000);
    put(1, mk(6'h02, 5'd4, 5'd12), 32'h0, 32'h2222_0000);
    flush = 1;
    put(1, mk(6'h00, 5'd1, 5'd13), 32'h0, 32'h3);
    put(1, mk(6'h21, 5'd0, 5'd14), 32'h0, 32'h3);
    flush = 0; out_ready = 1;
    repeat (3) put(0, 32'h0, 32'h0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ir;
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) ir = {6'($urandom_range(1, 63)), 26'($urandom)};
      else if (r == 1) ir = {6'd0, 20'($urandom), 6'h20 + 6'($urandom_range(0, 15))};
      else ir = {6'd0, 20'($urandom), legal_fn[$urandom_range(0, 5)]};
      flush = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      put(1'($urandom_range(0, 3) != 0), ir, $urandom, $urandom);
    end
    flush = 0; out_ready = 1;
    repeat (4) put(0, 32'h0, 32'h0, 32'h0);
    check_eq("final drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
